// File: rtl/serializador_izq_der.sv
// Bit-serial front end of the left-to-right comparison network: walks bits N-1..1 through the p/q cell recurrence.
// Result valid N-1 edges after accept (same edge for N=1); holds in HOLD until out_ready, in_ready only in IDLE.
module serializador_izq_der #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         pout,
    output logic         qout,
    output logic         a0,
    output logic         b0
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  a_sr_q;
    logic [N-1:0]  b_sr_q;
    logic [CW-1:0] cnt_q;
    logic          p_q;
    logic          q_q;
    logic          a0_q;
    logic          b0_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic          a_bit;
    logic          b_bit;
    logic          p_d;
    logic          q_d;
    logic          last_shift;

    // Typical cell: p stays set while bits match; q clears only when a 1 meets a 0 while still equal.
    always_comb begin
        a_bit      = a_sr_q[N-1];
        b_bit      = b_sr_q[N-1];
        p_d        = p_q & ~(a_bit ^ b_bit);
        q_d        = q_q & (~p_q | ~a_bit | b_bit);
        last_shift = (cnt_q == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            cnt_q       <= '0;
            p_q         <= 1'b1;
            q_q         <= 1'b1;
            a0_q        <= 1'b0;
            b0_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_q     <= a_in;
                        b_sr_q     <= b_in;
                        p_q        <= 1'b1;
                        q_q        <= 1'b1;
                        a0_q       <= a_in[0];
                        b0_q       <= b_in[0];
                        cnt_q      <= CW'(N - 1);
                        in_ready_q <= 1'b0;
                        if (N == 1) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    p_q    <= p_d;
                    q_q    <= q_d;
                    a_sr_q <= a_sr_q << 1;
                    b_sr_q <= b_sr_q << 1;
                    cnt_q  <= cnt_q - CW'(1);
                    if (last_shift) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    // No turnaround: a new pair is only taken once back in IDLE.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign pout      = p_q;
    assign qout      = q_q;
    assign a0        = a0_q;
    assign b0        = b0_q;

endmodule

// File: tb/tb_serializador_izq_der.sv
// Directed bench for serializador_izq_der with an N=8 and an N=1 instance sharing clock and reset.
module tb_serializador_izq_der;

    logic       clk;
    logic       reset;

    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a_in, b_in;
    logic       pout, qout, a0, b0;

    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0] a_in1, b_in1;
    logic       pout1, qout1, a01, b01;

    int total = 0;
    int bad   = 0;
    int n;
    logic sp, sq, sa, sb;

    serializador_izq_der #(.N(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pout(pout), .qout(qout), .a0(a0), .b0(b0)
    );

    serializador_izq_der #(.N(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .a_in(a_in1), .b_in(b_in1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .pout(pout1), .qout(qout1), .a0(a01), .b0(b01)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Final cell: if still equal, bit 0 decides; otherwise q already holds the answer.
    function automatic logic final_z(input logic p, input logic q, input logic a, input logic b);
        return p ? (~a | b) : q;
    endfunction

    task automatic accept8(input string tag, input logic [7:0] a, input logic [7:0] b);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; a_in = a; b_in = b;
        tick();
        in_valid = 1'b0; a_in = ~a; b_in = ~b;
    endtask

    task automatic wait_hold8(input string tag);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 7);
    endtask

    task automatic result8(input string tag, input logic p, input logic q,
                           input logic a, input logic b, input logic z);
        check({tag, "_pout"}, pout, p);
        check({tag, "_qout"}, qout, q);
        check({tag, "_a0"},   a0,   a);
        check({tag, "_b0"},   b0,   b);
        check({tag, "_z"},    final_z(pout, qout, a0, b0), z);
    endtask

    task automatic release8(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, out_valid, 0);
        check({tag, "_rel_ready"}, in_ready,  1);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a_in1 = '0; b_in1 = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready,  1);
        check("rst_pout",  pout,      1);
        check("rst_qout",  qout,      1);
        check("rst_a0",    a0,        0);
        check("rst_b0",    b0,        0);
        check("rst_ready1", in_ready1, 1);

        // Equal words
        accept8("eq", 8'h5A, 8'h5A);
        check("eq_shift_ready", in_ready, 0);
        wait_hold8("eq");
        result8("eq", 1, 1, 0, 0, 1);
        release8("eq");

        // A > B decided at the MSB
        accept8("gt", 8'h80, 8'h7F);
        wait_hold8("gt");
        result8("gt", 0, 0, 0, 1, 0);
        release8("gt");

        // A < B decided at the MSB
        accept8("lt", 8'h7F, 8'h80);
        wait_hold8("lt");
        result8("lt", 0, 1, 1, 0, 1);
        release8("lt");

        // Equal down to bit 1, bit 0 decides
        accept8("b0", 8'h03, 8'h02);
        wait_hold8("b0");
        result8("b0", 1, 1, 1, 0, 0);

        // Backpressure in HOLD
        sp = pout; sq = qout; sa = a0; sb = b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a_in = a_in + 8'h11;
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_ready", in_ready,  0);
            check("bp_hold",  {pout, qout, a0, b0}, 4'b1110);
        end
        check("bp_z", final_z(pout, qout, a0, b0), 0);
        in_valid = 1'b0;
        release8("bp");

        // Reset after 3 shift edges discards the word
        accept8("rs", 8'h80, 8'h7F);
        tick(); tick(); tick();
        check("rs_mid_p", pout, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_valid", out_valid, 0);
        check("rs_pout",  pout,      1);
        check("rs_qout",  qout,      1);
        check("rs_ready", in_ready,  1);
        accept8("rs2", 8'h7F, 8'h80);
        wait_hold8("rs2");
        result8("rs2", 0, 1, 1, 0, 1);
        release8("rs2");

        // N=1 instance
        check("n1_ready", in_ready1, 1);
        in_valid1 = 1'b1; a_in1 = 1'b1; b_in1 = 1'b0;
        tick();
        in_valid1 = 1'b0;
        check("n1a_valid", out_valid1, 1);
        check("n1a_ready", in_ready1,  0);
        check("n1a_res", {pout1, qout1, a01, b01}, 4'b1110);
        check("n1a_z", final_z(pout1, qout1, a01, b01), 0);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("n1a_rel", {out_valid1, in_ready1}, 2'b01);
        in_valid1 = 1'b1; a_in1 = 1'b0; b_in1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        check("n1b_valid", out_valid1, 1);
        check("n1b_res", {pout1, qout1, a01, b01}, 4'b1101);
        check("n1b_z", final_z(pout1, qout1, a01, b01), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serializador_izq_der.md
Name: serializador_izq_der

Overview:
- Bit-serial front end of the left-to-right iterative comparison network.
- Accepts an N-bit word pair (A, B) over a valid/ready handshake.
- Walks bits N-1 down to 1 in time, one bit per clock. It applies the typical-cell recurrence for p ("equal so far") and q ("A<=B still holds") at each bit.
- Presents pout, qout, A0 and B0 to the final cell of the network, which produces Z = (A <= B), unsigned.

Parameters:
- N, 8, word width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream word pair valid
- in_ready  output  1  block can accept a pair; high only in IDLE
- a_in  input  N  word A
- b_in  input  N  word B
- out_valid  output  1  pout/qout/a0/b0 are final and stable
- out_ready  input  1  downstream (final cell consumer) accepts result
- pout  output  1  p after bits N-1..1
- qout  output  1  q after bits N-1..1
- a0  output  1  bit 0 of the accepted A
- b0  output  1  bit 0 of the accepted B

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - out_valid = 0
  - pout = 1, qout = 1
  - a0 = 0, b0 = 0
  - internal shift registers and bit counter = 0
  - in_ready = 1 from the first cycle after reset deasserts
- States: IDLE, SHIFT, HOLD.
  - in_ready = (state == IDLE).
  - out_valid = (state == HOLD).
- IDLE, on an edge where in_valid & in_ready:
  - latch a_in and b_in
  - set p = 1, q = 1
  - set a0 = a_in[0], b0 = b_in[0]
  - set counter = N-1
  - next state is HOLD if N == 1, otherwise SHIFT.
- SHIFT, on each edge:
  - take a = A[msb], b = B[msb] of the shift registers
  - p_next = p & ~(a ^ b)
  - q_next = q & (~p | ~a | b)
  - shift both registers left by 1 and decrement the counter
  - after the edge that processes bit 1 (counter 1 -> 0), go to HOLD.
  - Exactly N-1 SHIFT edges occur.
- Latency: with the accept edge at t0, out_valid rises after edge t0+(N-1). For N = 1 it rises after t0 itself.
- HOLD:
  - pout, qout, a0, b0 are held constant.
  - in_valid is ignored and in_ready = 0.
  - On an edge with out_ready = 1, go to IDLE; out_valid drops in the next cycle.
  - A new pair can be accepted no earlier than the cycle after leaving HOLD; there is no same-cycle turnaround.
- pout and qout are registered and change only in SHIFT, on accept, or on reset. Downstream must not sample them unless out_valid = 1.
- In IDLE and SHIFT, in_valid with no accept has no effect. Inputs are sampled only on the accept edge, so a_in/b_in may change freely afterwards.
- Reset asserted in any state, including mid-SHIFT or in HOLD with out_ready low, overrides all else: IDLE and reset values on the next edge. The pending word is discarded.
- q never returns to 1 once 0. p never returns to 1 once 0 within a word.

Test Plan:
- N=8, A=0x5A, B=0x5A, out_ready=1 -> out_valid rises 7 edges after accept; pout=1, qout=1, a0=0, b0=0; final-cell Z=1. in_ready returns 1 the following cycle.
- N=8, A=0x80, B=0x7F -> bit 7 gives p=0, q=0; final pout=0, qout=0, a0=0, b0=1; Z=0.
- N=8, A=0x7F, B=0x80 -> pout=0, qout=1, a0=1, b0=0; Z=1. Then A=0x03, B=0x02 -> pout=1, qout=1, a0=1, b0=0; Z=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while toggling in_valid and a_in -> outputs stable, in_ready=0, no new accept. Raise out_ready -> IDLE next cycle.
- Assert reset for one cycle after 3 SHIFT edges -> next cycle state is IDLE, out_valid=0, pout=1, qout=1, in_ready=1. A fresh pair completes correctly.
- N=1: A=1, B=0 -> out_valid high the cycle after accept; pout=1, qout=1, a0=1, b0=0; Z=0. A=0, B=1 -> Z=1.
